// File: rtl/frame_fetcher.sv
// Framebuffer scan-out: reads one 32-bit word per pixel from SDRAM in raster
// order, buffers the RGB part in a small FIFO and streams it out as valid/ready.
module frame_fetcher #(
  parameter logic [31:0] BASE_ADDR  = 32'h40C00000,
  parameter logic [31:0] BUF_OFFSET = 32'h00200000,
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          DEPTH      = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] sd_addr,
  output logic        sd_rw,
  output logic        sd_in_valid,
  input  logic [31:0] sd_data_out,
  input  logic        sd_done,
  input  logic        fbuffer,
  input  logic        vsync,
  output logic [23:0] pix_rgb,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [1:0] {S_WAITV, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state_reg, state_next;
  logic          vs_q;
  logic          buf_reg, buf_next;
  logic          discard_reg, discard_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [31:0]   ptr_reg, ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [23:0]   mem [DEPTH];

  logic          vs_rise;
  logic [31:0]   base_new, base_cur;
  logic          last_px;
  logic          flush, push, pop, do_push, do_pop;
  logic          done_next, strobe_next, valid_next;
  logic [31:0]   addr_next;
  logic [23:0]   head_next;
  logic          unused_hi;

  assign sd_rw     = 1'b0;
  assign unused_hi = ^sd_data_out[31:24];

  assign vs_rise  = vsync & ~vs_q;
  assign base_new = BASE_ADDR + (fbuffer ? BUF_OFFSET : 32'd0);
  assign base_cur = BASE_ADDR + (buf_reg ? BUF_OFFSET : 32'd0);
  assign last_px  = (x_reg == X_LAST) && (y_reg == Y_LAST);

  // Sequencing of reads, frame position and restart handling
  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    ptr_next     = ptr_reg;
    buf_next     = buf_reg;
    discard_next = discard_reg;
    done_next    = frame_done;
    flush        = 1'b0;
    push         = 1'b0;
    case (state_reg)
      S_WAITV, S_DONE: begin
        if (vs_rise) begin
          state_next   = S_ISSUE;
          buf_next     = fbuffer;
          x_next       = '0;
          y_next       = '0;
          ptr_next     = base_new;
          discard_next = 1'b0;
          flush        = 1'b1;
          done_next    = 1'b0;
        end
      end
      S_ISSUE: begin
        if (vs_rise) begin
          buf_next  = fbuffer;
          flush     = 1'b1;
          done_next = 1'b0;
          if (sd_in_valid) begin
            // the strobe already left this cycle, so that read must be drained
            state_next   = S_WAIT;
            discard_next = 1'b1;
          end else begin
            x_next   = '0;
            y_next   = '0;
            ptr_next = base_new;
          end
        end else if (sd_in_valid) begin
          state_next = S_WAIT;
          if (last_px) done_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (vs_rise) begin
          buf_next  = fbuffer;
          flush     = 1'b1;
          done_next = 1'b0;
          if (sd_done) begin
            state_next   = S_ISSUE;
            x_next       = '0;
            y_next       = '0;
            ptr_next     = base_new;
            discard_next = 1'b0;
          end else begin
            discard_next = 1'b1;
          end
        end else if (sd_done) begin
          if (discard_reg) begin
            state_next   = S_ISSUE;
            x_next       = '0;
            y_next       = '0;
            ptr_next     = base_cur;
            discard_next = 1'b0;
          end else begin
            push     = 1'b1;
            ptr_next = ptr_reg + 32'd4;
            if (x_reg == X_LAST) begin
              x_next = '0;
              if (y_reg == Y_LAST) begin
                state_next = S_DONE;
              end else begin
                y_next     = y_reg + YW'(1);
                state_next = S_ISSUE;
              end
            end else begin
              x_next     = x_reg + XW'(1);
              state_next = S_ISSUE;
            end
          end
        end
      end
      default: state_next = S_WAITV;
    endcase
  end

  // FIFO bookkeeping; flush wins over push and pop
  always_comb begin
    pop         = pix_valid & pix_ready;
    do_push     = push & ~flush;
    do_pop      = pop & ~flush;
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    head_next   = pix_rgb;
    if (flush) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
      if (do_push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      // head register tracks the entry at rd_ptr so the output is fall-through
      if (do_push && (count_reg == '0 || (do_pop && count_reg == CW'(1))))
        head_next = sd_data_out[23:0];
      else if (do_pop && count_reg > CW'(1))
        head_next = mem[rd_ptr_reg + AW'(1)];
    end
    valid_next  = (count_next != '0);
    strobe_next = (state_next == S_ISSUE) && (count_next < FULL);
    addr_next   = strobe_next ? ptr_next : sd_addr;
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= sd_data_out[23:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_WAITV;
      vs_q        <= 1'b0;
      buf_reg     <= 1'b0;
      discard_reg <= 1'b0;
      x_reg       <= '0;
      y_reg       <= '0;
      ptr_reg     <= '0;
      count_reg   <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      sd_addr     <= '0;
      sd_in_valid <= 1'b0;
      pix_rgb     <= '0;
      pix_valid   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      vs_q        <= vsync;
      buf_reg     <= buf_next;
      discard_reg <= discard_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      ptr_reg     <= ptr_next;
      count_reg   <= count_next;
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      sd_addr     <= addr_next;
      sd_in_valid <= strobe_next;
      pix_rgb     <= head_next;
      pix_valid   <= valid_next;
      frame_done  <= done_next;
    end
  end

endmodule

// File: doc/frame_fetcher.md
# frame_fetcher

Framebuffer scan-out stage downstream of `frame_drawer`. It reads the displayed framebuffer (`fbuffer`) out of SDRAM in raster order through the single-request SDRAM port, one 32-bit word per pixel. It buffers the pixels in a small FIFO and presents them as a 24-bit RGB valid/ready stream to the video output stage. Each rising edge of `vsync` restarts it at pixel (0,0) of the currently selected buffer.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h40C00000: byte address of pixel (0,0) of buffer 0.
- `BUF_OFFSET`, default 32'h00200000: byte offset from buffer 0 to buffer 1.
- `H_RES`, default 640: pixels per line.
- `V_RES`, default 480: lines per frame.
- `DEPTH`, default 16: FIFO entries; must be a power of two, 4..256.

Ports:
- `clock`, in, 1: sole clock. All logic is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset. It asserts asynchronously and is released synchronously by the instantiating logic.
- `sd_addr`, out, 32: SDRAM byte address of the current read.
- `sd_rw`, out, 1: always 0 (read).
- `sd_in_valid`, out, 1: one-cycle request strobe.
- `sd_data_out`, in, 32: read data; bits [23:0] are RGB. It is sampled only in the cycle where `sd_done`=1.
- `sd_done`, in, 1: read completion, one cycle.
- `fbuffer`, in, 1: buffer being displayed. Sampled only on a `vsync` rising edge.
- `vsync`, in, 1: frame sync from the video timing generator. Level input.
- `pix_rgb`, out, 24: pixel data.
- `pix_valid`, out, 1: `pix_rgb` holds a pixel.
- `pix_ready`, in, 1: consumer accepts the pixel this cycle.
- `frame_done`, out, 1: high from issue of the final pixel read until the next `vsync` rise.

## Operation
- **Vsync edge detect.** `vsync` is registered once (`vs_q`). A rise (`vsync & ~vs_q`) generates `vs_rise`.
- **Address.** The address is `BASE_ADDR + (buf ? BUF_OFFSET : 0) + (y*H_RES + x)*4`.
  - Computed as a running 32-bit pointer: +4 per pixel, with no multiplier.
  - `buf` is the `fbuffer` value latched on `vs_rise`.
- **FSM states:** WAITV, ISSUE, WAIT, DONE.
  - WAITV: idle after reset. On `vs_rise`: latch `buf`, clear x/y, load the pointer, flush the FIFO, go to ISSUE.
  - ISSUE: if `count + 1 <= DEPTH` (a slot is free, including the in-flight slot), drive `sd_addr` = pointer and pulse `sd_in_valid` for one cycle, then go to WAIT. Otherwise stay.
  - WAIT: stay until `sd_done`=1.
    - On `sd_done`, push `sd_data_out[23:0]` unless the discard flag is set.
    - Then advance x. When x wraps to 0, increment y.
    - Go to ISSUE, or to DONE if the pixel just requested was (H_RES-1, V_RES-1).
  - DONE: `frame_done`=1. On `vs_rise`, behave as WAITV does.
- **`vs_rise` in ISSUE or DONE:** restart immediately, as in WAITV.
- **`vs_rise` in WAIT:**
  - The outstanding SDRAM read cannot be aborted.
  - Set the discard flag, flush the FIFO, and latch `buf`.
  - When `sd_done` arrives, drop the data, clear the discard flag, and restart at (0,0) in ISSUE.
- **FIFO.**
  - Count width is log2(DEPTH)+1.
  - Pop when `pix_valid & pix_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - Flush forces the count to 0 and overrides any push or pop in the same cycle.
  - The FIFO never overflows, because ISSUE is gated on free space.
- **Output.** `pix_valid` = (count != 0). `pix_rgb` = head entry (registered storage, first-word fall-through).
- **Reset values:** `sd_addr`=0, `sd_rw`=0, `sd_in_valid`=0, `pix_rgb`=0, `pix_valid`=0, `frame_done`=0; FSM=WAITV, count=0, x=y=0, discard=0, `vs_q`=0.

## Timing
- **`vs_rise` to first request:** `vsync` is sampled high in cycle N with `vs_q`=0, so the FSM enters ISSUE in N+1 and `sd_in_valid` is asserted in N+1.
- **Request handshake:**
  - `sd_in_valid` is high for exactly one cycle per read.
  - `sd_addr` is held stable from the strobe until `sd_done`.
  - At most one read is outstanding.
- **Read to output:** `sd_done` in cycle M makes the data visible on `pix_rgb`/`pix_valid` in M+1, if the FIFO was empty.
- **Back-to-back reads:** `sd_done` in M lets the next `sd_in_valid` occur in M+1. Sustained rate is 1 pixel per (SDRAM latency + 1) cycles.
- **Flush visibility:** `pix_valid` falls in the cycle after `vs_rise`.
- **Reset mid-transaction:** reset discards all state. A late `sd_done` arriving while in WAITV is ignored.

## Test plan
- **Basic frame, H_RES=4, V_RES=2, fbuffer=0:** pulse vsync; an SDRAM model returns addr[23:0] after 3 cycles; `pix_ready`=1.
  - Required: requests at 0x40C00000, 0x40C00004 … 0x40C0001C, exactly one strobe each.
  - Required: pixel stream equals the low 24 bits of those addresses, in order.
  - Required: `frame_done`=1 after the 8th request and no 9th request.
- **Buffer select:** `fbuffer`=1 at `vs_rise`; toggle it to 0 mid-frame.
  - Required: all 8 addresses are based at 0x40E00000.
- **Backpressure, DEPTH=4:** hold `pix_ready`=0.
  - Required: exactly 4 reads, then `sd_in_valid` stays low.
  - Release `pix_ready` for 1 cycle. Required: 1 more read is issued, and pixel order is preserved.
- **Vsync during WAIT:** raise `vsync` while a read is outstanding.
  - Required: the FIFO is flushed (`pix_valid`=0 next cycle).
  - Required: the returned word is not output, and the next request is at address 0x40C00000.
- **Simultaneous push and pop:** `sd_done` coincides with a pop while count=2.
  - Required: count stays 2, and the data sequence is unbroken.
- **Async reset:** drop `reset` to 0 mid-frame, between clock edges.
  - Required: all outputs are immediately at their reset values.
  - Required: after release, no request is issued until the next `vs_rise`.
